// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to the synchronous program
// memory, and buffers returned words in a 2-entry FIFO. Decode reads {instr, pc}
// from the FIFO head over a valid/ready handshake. The stage also handles
// redirect and halt.
module fetch_unit #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [ADDR_WIDTH-1:0]  PC_STEP     = ADDR_WIDTH'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    input  logic                   halt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                    inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]   tag_q, tag_d;
    logic                    halted_q;

    logic [INSTR_WIDTH-1:0]  fifo_instr_q [2];
    logic [ADDR_WIDTH-1:0]   fifo_pc_q    [2];
    logic                    rd_ptr_q, wr_ptr_q;
    logic [1:0]              count_q;

    logic                    pop_c;
    logic                    push_c;
    logic [1:0]              occ_c;
    logic                    issue_c;

    // Handshake and issue decisions; occupancy counts the slot reserved by the in-flight word
    always_comb begin
        pop_c   = (count_q != 2'd0) & out_ready;
        push_c  = inflight_q & ~redirect_valid;
        occ_c   = 2'(count_q - 2'(pop_c) + 2'(inflight_q));
        issue_c = (state_q == ST_RUN) && !halt && (occ_c < 2'd2);
    end

    assign imem_req  = issue_c & ~rst;
    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = fifo_instr_q[rd_ptr_q];
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign halted    = halted_q;

    // Next-state, PC and in-flight tracking; redirect overrides everything else
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = inflight_q ? ST_DRAIN : ST_HALTED;
                end else if (issue_c) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    inflight_d = 1'b1;
                    tag_d      = fetch_pc_q;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            state_d    = halt ? ST_HALTED : ST_RUN;
        end
    end

    // State, PC and in-flight registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            halted_q   <= (state_d == ST_HALTED);
        end
    end

    // Two-entry response FIFO; a redirect empties it, discarding the returning word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_c) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata;
                fifo_pc_q[wr_ptr_q]    <= tag_q;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= 2'(count_q + 2'(push_c) - 2'(pop_c));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. A scoreboard holds the expected instruction stream,
// which is rebuilt from the target whenever reset or a redirect takes effect.
// A monitor compares every word that decode accepts against that stream.
// Directed checks cover cycle-level behaviour.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } word_t;

    word_t exp_q[$];
    word_t exp_w;
    int    checks = 0;
    int    errors = 0;
    int    since_redirect;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: word at address a holds a + 0x100, returned one cycle after the request
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr + 32'h100;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream after a restart at start: consecutive word addresses, wrapping at 2^32
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] p;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            p = start + 32'(i);
            exp_q.push_back('{instr: p + 32'h100, pc: p});
        end
    endtask

    task automatic sync_drive();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted word must be the next expected word; no fetch while halted
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got pc %h instr %h, expected no word", out_pc, out_instr);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("sb_pc", 64'(out_pc), 64'(exp_w.pc));
                    check("sb_instr", 64'(out_instr), 64'(exp_w.instr));
                end
            end
            if (halted) check("no_req_when_halted", 64'(imem_req), 64'd0);
        end
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        out_ready      = 1'b0;
        since_redirect = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // Streaming from reset: one request per cycle, first word two cycles later
        load_stream(32'h0);
        out_ready = 1'b1;
        rst       = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t1_req", 64'(imem_req), 64'd1);
            check("t1_addr", 64'(imem_addr), 64'(k));
            check("t1_valid", 64'(out_valid), 64'(k >= 2));
        end

        // Backpressure: requests stop once the FIFO plus in-flight word fill two slots
        sync_drive();
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_req_dropped", 64'(imem_req), 64'd0);
        check("t2_valid_held", 64'(out_valid), 64'd1);
        sync_drive();
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Redirect while full, with a same-cycle pop of the old head
        sync_drive();
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_full", 64'(out_valid), 64'd1);
        sync_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        out_ready      = 1'b1;
        sync_drive();
        redirect_valid = 1'b0;
        load_stream(32'h40);
        @(negedge clk);
        check("t3_valid_flushed", 64'(out_valid), 64'd0);
        check("t3_req", 64'(imem_req), 64'd1);
        check("t3_addr", 64'(imem_addr), 64'h40);
        repeat (10) @(negedge clk);

        // Halt pulse with a request in flight
        sync_drive();
        halt = 1'b1;
        @(negedge clk);
        check("t4_halt_cycle_req", 64'(imem_req), 64'd0);
        sync_drive();
        halt = 1'b0;
        @(negedge clk);
        check("t4_drain_halted", 64'(halted), 64'd0);
        check("t4_drain_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("t4_halted", 64'(halted), 64'd1);
        repeat (6) @(negedge clk);
        check("t4_still_halted", 64'(halted), 64'd1);
        check("t4_drained", 64'(out_valid), 64'd0);
        sync_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        sync_drive();
        redirect_valid = 1'b0;
        load_stream(32'h10);
        @(negedge clk);
        check("t4_resume_req", 64'(imem_req), 64'd1);
        check("t4_resume_addr", 64'(imem_addr), 64'h10);
        check("t4_resume_halted", 64'(halted), 64'd0);
        repeat (8) @(negedge clk);

        // PC wrap past the top of the address space
        sync_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        sync_drive();
        redirect_valid = 1'b0;
        load_stream(32'hFFFF_FFFF);
        repeat (8) @(negedge clk);

        // Randomised traffic: backpressure, redirects and halts
        for (int c = 0; c < 1500; c++) begin
            sync_drive();
            if (redirect_valid) begin
                redirect_valid = 1'b0;
                load_stream(redirect_pc);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            halt      = ($urandom_range(0, 29) == 0);
            since_redirect++;
            if (since_redirect >= 40 || $urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                                               : 32'($urandom_range(0, 32'hFFFF));
                since_redirect = 0;
            end
        end
        sync_drive();
        if (redirect_valid) begin
            redirect_valid = 1'b0;
            load_stream(redirect_pc);
        end
        halt      = 1'b0;
        out_ready = 1'b1;

        // Reset asserted mid-stream takes effect without a clock edge
        sync_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        out_ready      = 1'b0;
        sync_drive();
        redirect_valid = 1'b0;
        load_stream(32'h200);
        repeat (4) @(negedge clk);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_addr", 64'(imem_addr), 64'd0);
        check("t6_req", 64'(imem_req), 64'd0);
        exp_q.delete();
        sync_drive();
        load_stream(32'h0);
        out_ready = 1'b1;
        rst       = 1'b0;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
